seg7_capture: RTL

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// seg7_capture: observes a multiplexed 7-segment display bus (digit selects
// plus segment lines, all active-low) and reconstructs the value shown on
// each digit. A digit is captured only after its select/segment pattern has
// been stable for STABLE_CYCLES consecutive registered samples.
module seg7_capture #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [7:0]            seg,
    output logic [4*DIGITS-1:0]   digit_val,
    output logic [DIGITS-1:0]     dot_val,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     err,
    output logic                  upd,
    output logic [2:0]            upd_idx
);

    localparam int          SW         = DIGITS + 8;
    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);

    // samp_p0 is the current registered sample, samp_p1 the one before it
    logic [SW-1:0] samp_p0;
    logic [SW-1:0] samp_p1;
    logic [7:0]    cnt;
    logic [7:0]    cnt_next;
    logic [3:0]    lowcnt;
    logic          sel_ok;
    logic [2:0]    sel_idx;
    logic          commit;
    logic          dec_legal;
    logic          dec_blank;
    logic [3:0]    dec_val;

    // Returns {legal, blank, value} for an active-low a..g pattern
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = {2'b10, 4'h0};
            7'b1111001: decode = {2'b10, 4'h1};
            7'b0100100: decode = {2'b10, 4'h2};
            7'b0110000: decode = {2'b10, 4'h3};
            7'b0011001: decode = {2'b10, 4'h4};
            7'b0010010: decode = {2'b10, 4'h5};
            7'b0000010: decode = {2'b10, 4'h6};
            7'b1111000: decode = {2'b10, 4'h7};
            7'b0000000: decode = {2'b10, 4'h8};
            7'b0010000: decode = {2'b10, 4'h9};
            7'b0001000: decode = {2'b10, 4'hA};
            7'b0000011: decode = {2'b10, 4'hB};
            7'b1000110: decode = {2'b10, 4'hC};
            7'b0100001: decode = {2'b10, 4'hD};
            7'b0000110: decode = {2'b10, 4'hE};
            7'b0001110: decode = {2'b10, 4'hF};
            7'b1111111: decode = {2'b01, 4'h0};
            default:    decode = {2'b00, 4'h0};
        endcase
    endfunction

    // Selecting means exactly one active-low digit select in the sample
    always_comb begin
        lowcnt  = '0;
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!samp_p0[8+i]) begin
                lowcnt  = lowcnt + 4'd1;
                sel_idx = 3'(i);
            end
        end
        sel_ok = (lowcnt == 4'd1);
    end

    // Stability count and commit decision; commit fires once, on reaching the limit
    always_comb begin
        if (!sel_ok || (samp_p0 != samp_p1)) begin
            cnt_next = 8'd1;
        end else if (cnt >= STABLE_MAX) begin
            cnt_next = STABLE_MAX;
        end else begin
            cnt_next = cnt + 8'd1;
        end
        commit = sel_ok && (cnt_next == STABLE_MAX) && (cnt != STABLE_MAX);
        {dec_legal, dec_blank, dec_val} = decode(samp_p0[6:0]);
    end

    // Input sampling and stability counter; reset leaves the sample idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_p0 <= '1;
            samp_p1 <= '1;
            cnt     <= '0;
        end else begin
            samp_p0 <= {an, seg};
            samp_p1 <= samp_p0;
            cnt     <= cnt_next;
        end
    end

    // Per-digit result registers; only the committed digit is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val <= '0;
            dot_val   <= '0;
            valid     <= '0;
            err       <= '0;
            upd       <= 1'b0;
            upd_idx   <= '0;
        end else begin
            upd <= commit;
            if (commit) begin
                upd_idx <= sel_idx;
            end
            for (int i = 0; i < DIGITS; i++) begin
                if (commit && (sel_idx == 3'(i))) begin
                    dot_val[i] <= ~samp_p0[7];
                    if (dec_legal) begin
                        digit_val[4*i +: 4] <= dec_val;
                        valid[i]            <= 1'b1;
                        err[i]              <= 1'b0;
                    end else if (dec_blank) begin
                        valid[i] <= 1'b0;
                        err[i]   <= 1'b0;
                    end else begin
                        valid[i] <= 1'b0;
                        err[i]   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
